// File: rtl/fifo_rd_pkg.sv
// Shared constants and helpers for the async-FIFO read-side packer.
package fifo_rd_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int PACK_DEF     = 2;
  localparam int PACK_MAX     = 8;

  // Width of a counter that must hold 0..pack inclusive.
  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

  function automatic logic [PACK_MAX-1:0] keep_mask(input int n);
    logic [PACK_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < PACK_MAX; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed output stream of fifo_rd_packer.
interface fifo_rd_packer_if
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int PACK     = PACK_DEF
);
  // rinc pops the show-ahead head word on any rclk edge where it is high (never while rempty).
  // A beat transfers on an rclk edge with out_valid && out_ready; out_data/out_keep hold while stalled.
  logic                     rempty;
  logic [DATASIZE-1:0]      rdata;
  logic                     rinc;
  logic                     flush;
  logic [DATASIZE*PACK-1:0] out_data;
  logic [PACK-1:0]          out_keep;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    input  rempty, rdata, flush, out_ready,
    output rinc, out_data, out_keep, out_valid
  );

  modport slave (
    output rempty, rdata, flush, out_ready,
    input  rinc, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_rd_idle_timer.sv
// Idle counter that asks for a flush after TIMEOUT quiet cycles with a partial beat.
module fifo_rd_idle_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  localparam int             W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  // Saturates at LIMIT so a stalled output cannot wrap the counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && count != LIMIT) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == LIMIT);
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops words from the async FIFO and packs PACK of them into one valid/ready beat.
// Optional idle auto-flush is compiled in with RD_PACK_TIMEOUT_EN.
module fifo_rd_packer
  import fifo_rd_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int PACK     = PACK_DEF,
  parameter int TIMEOUT  = 15
) (
  input  logic             rclk,
  input  logic             rrst,
  fifo_rd_packer_if.master bus
);
  localparam int               CNT_W    = cnt_width(PACK);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK);

  logic [PACK-1:0][DATASIZE-1:0] asm_q;
  logic [PACK-1:0][DATASIZE-1:0] beat_data;
  logic [CNT_W-1:0]              cnt;
  logic [CNT_W-1:0]              cnt_next;
  logic                          flush_pend;
  logic                          flush_pend_next;
  logic                          has_words;
  logic                          pop;
  logic                          move;
  logic                          flush_req;
  logic                          timeout_hit;

  assign has_words = (cnt != '0);
  assign move      = (cnt == CNT_FULL || (flush_pend && has_words)) &&
                     (!bus.out_valid || bus.out_ready);
  // A full assembly register may still pop when it empties into the output this cycle.
  assign pop       = !rrst && !bus.rempty && !flush_pend && (cnt != CNT_FULL || move);
  assign bus.rinc  = pop;

  always_comb begin
    cnt_next = cnt;
    if (move) begin
      cnt_next = pop ? CNT_W'(1) : '0;
    end else if (pop) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  // A flush only sticks if words remain after this edge, so no empty beat is ever made.
  assign flush_req       = bus.flush || timeout_hit;
  assign flush_pend_next = (flush_req && cnt_next != '0) || (flush_pend && !move);

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < PACK; i++) begin
      if (i < int'(cnt)) beat_data[i] = asm_q[i];
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      asm_q         <= '0;
      cnt           <= '0;
      flush_pend    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_keep  <= '0;
    end else begin
      cnt        <= cnt_next;
      flush_pend <= flush_pend_next;
      for (int i = 0; i < PACK; i++) begin
        if (pop && (move ? (i == 0) : (int'(cnt) == i))) asm_q[i] <= bus.rdata;
      end
      if (move) begin
        bus.out_data  <= beat_data;
        bus.out_keep  <= PACK'(keep_mask(int'(cnt)));
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef RD_PACK_TIMEOUT_EN
  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk (rclk),
    .rst (rrst),
    .inc (has_words && !pop && !flush_pend),
    .clr (pop || move),
    .hit (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
`endif

endmodule
